// File: rtl/otter_wb_pkg.sv
// Shared widths and the writeback request record for the OTTER writeback arbiter.
package otter_wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int WB_XLEN    = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
  } wb_req_t;
endpackage

// File: rtl/otter_wb_fifo.sv
// Synchronous FIFO of writeback requests; extra pointer MSB distinguishes full from empty.
module otter_wb_fifo
  import otter_wb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_req_t
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);
  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/otter_wb_arbiter.sv
// Register-file writeback arbiter (primary wins, long-latency results queued) plus pending scoreboard.
// Define OTTER_WB_BYPASS_EN to add operand bypass outputs and commit-cycle stall suppression.
module otter_wb_arbiter
  import otter_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pri_valid,
  input  logic [REG_ADDR_W-1:0] pri_rd,
  input  logic [XLEN-1:0]       pri_data,
  input  logic                  sec_valid,
  output logic                  sec_ready,
  input  logic [REG_ADDR_W-1:0] sec_rd,
  input  logic [XLEN-1:0]       sec_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wa,
  output logic [XLEN-1:0]       rf_wd,
`ifdef OTTER_WB_BYPASS_EN
  output logic                  byp1_hit,
  output logic                  byp2_hit,
  output logic [XLEN-1:0]       byp1_data,
  output logic [XLEN-1:0]       byp2_data,
`endif
  output logic [NUM_REGS-1:0]   pending
);
  // Same layout as wb_req_t, sized to this instance's XLEN.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } req_t;

  req_t                sec_req;
  req_t                head;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // Secondary handshake: a result transfers on any rising edge where sec_valid && sec_ready;
  // sec_ready depends only on the registered full flag, never on a same-cycle pop.
  assign sec_ready = !full && !reset;
  assign push      = sec_valid && sec_ready;
  assign sec_req   = '{rd: sec_rd, data: sec_data};

  otter_wb_fifo #(.DEPTH(DEPTH), .entry_t(req_t)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (sec_req),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // x0 requests are consumed but never enable the write port.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    pop   = 1'b0;
    if (!reset) begin
      if (pri_valid) begin
        rf_we = (pri_rd != '0);
        rf_wa = pri_rd;
        rf_wd = pri_data;
      end else if (!empty) begin
        pop   = 1'b1;
        rf_we = (head.rd != '0);
        rf_wa = head.rd;
        rf_wd = head.data;
      end
    end
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid) set_vec[iss_rd] = 1'b1;
    if (pop)       clr_vec[head.rd] = 1'b1;
    set_vec[0] = 1'b0;
    clr_vec[0] = 1'b0;
  end

  // Clear first, then set, so a same-cycle issue to a committing register stays pending.
  always_ff @(posedge clock) begin
    if (reset) pending_q <= '0;
    else       pending_q <= (pending_q & ~clr_vec) | set_vec;
  end

  assign pending = pending_q;

`ifdef OTTER_WB_BYPASS_EN
  assign stall     = (pending_q[rs1] && !clr_vec[rs1]) || (pending_q[rs2] && !clr_vec[rs2]);
  assign byp1_hit  = rf_we && (rf_wa == rs1) && (rs1 != '0);
  assign byp2_hit  = rf_we && (rf_wa == rs2) && (rs2 != '0);
  assign byp1_data = rf_wd;
  assign byp2_data = rf_wd;
`else
  assign stall = pending_q[rs1] || pending_q[rs2];
`endif

  a_no_waw_issue: assert property (@(posedge clock) disable iff (reset)
    (iss_valid && iss_rd != '0) |-> (!pending_q[iss_rd] || clr_vec[iss_rd]));

  a_no_pri_to_pending: assert property (@(posedge clock) disable iff (reset)
    (pri_valid && pri_rd != '0) |-> !pending_q[pri_rd]);
endmodule

// File: tb/tb_otter_wb_arbiter.sv
// Bench for otter_wb_arbiter: directed scenarios then randomized traffic against a queue-based model.
module tb_otter_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int EW    = 5 + XLEN;

  logic            clock = 1'b0;
  logic            reset;
  logic            pri_valid;
  logic [4:0]      pri_rd;
  logic [XLEN-1:0] pri_data;
  logic            sec_valid;
  logic            sec_ready;
  logic [4:0]      sec_rd;
  logic [XLEN-1:0] sec_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            stall;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic [31:0]     pending;
`ifdef OTTER_WB_BYPASS_EN
  logic            byp1_hit;
  logic            byp2_hit;
  logic [XLEN-1:0] byp1_data;
  logic [XLEN-1:0] byp2_data;
`endif

  otter_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock     (clock),
    .reset     (reset),
    .pri_valid (pri_valid),
    .pri_rd    (pri_rd),
    .pri_data  (pri_data),
    .sec_valid (sec_valid),
    .sec_ready (sec_ready),
    .sec_rd    (sec_rd),
    .sec_data  (sec_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .stall     (stall),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
`ifdef OTTER_WB_BYPASS_EN
    .byp1_hit  (byp1_hit),
    .byp2_hit  (byp2_hit),
    .byp1_data (byp1_data),
    .byp2_data (byp2_data),
`endif
    .pending   (pending)
  );

  // Clock and reset.
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: queued secondary results in acceptance order, and the pending set.
  logic [EW-1:0]   exp_q[$];
  logic [31:0]     pend_m;
  logic [4:0]      out_q[$];
  logic            e_we;
  logic [4:0]      e_wa;
  logic [XLEN-1:0] e_wd;
  logic            e_ready;
  logic            pop_m;
  logic            acc_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge and compare every output with the model's prediction.
  task automatic settle();
    logic s1;
    logic s2;
    @(negedge clock);
    pop_m = 1'b0;
    e_we  = 1'b0;
    e_wa  = '0;
    e_wd  = '0;
    if (reset) begin
      e_ready = 1'b0;
    end else begin
      e_ready = (exp_q.size() < DEPTH);
      if (pri_valid) begin
        e_we = (pri_rd != 0);
        e_wa = pri_rd;
        e_wd = pri_data;
      end else if (exp_q.size() > 0) begin
        pop_m = 1'b1;
        e_wa  = exp_q[0][EW-1:XLEN];
        e_wd  = exp_q[0][XLEN-1:0];
        e_we  = (e_wa != 0);
      end
    end
    s1 = pend_m[rs1];
    s2 = pend_m[rs2];
`ifdef OTTER_WB_BYPASS_EN
    if (pop_m && e_we && e_wa == rs1) s1 = 1'b0;
    if (pop_m && e_we && e_wa == rs2) s2 = 1'b0;
    check("byp1_hit", byp1_hit, e_we && e_wa == rs1 && rs1 != 0);
    check("byp2_hit", byp2_hit, e_we && e_wa == rs2 && rs2 != 0);
    if (e_we && e_wa == rs1 && rs1 != 0) check("byp1_data", byp1_data, e_wd);
    if (e_we && e_wa == rs2 && rs2 != 0) check("byp2_data", byp2_data, e_wd);
`endif
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_wa", rf_wa, e_wa);
      check("rf_wd", rf_wd, e_wd);
    end
    check("sec_ready", sec_ready, e_ready);
    check("stall", stall, s1 | s2);
    check("pending", pending, pend_m);
  endtask

  // Advance one rising edge and apply its effects to the model.
  task automatic tick();
    @(posedge clock);
    acc_m = !reset && sec_valid && e_ready;
    if (reset) begin
      exp_q.delete();
      pend_m = '0;
    end else begin
      if (pop_m) begin
        if (e_wa != 0) pend_m[e_wa] = 1'b0;
        void'(exp_q.pop_front());
      end
      if (acc_m) exp_q.push_back({sec_rd, sec_data});
      if (iss_valid && iss_rd != 0) pend_m[iss_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    pri_valid = 1'b0; pri_rd = '0; pri_data = '0;
    sec_valid = 1'b0; sec_rd = '0; sec_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    rs1 = '0; rs2 = '0;
  endtask

  initial begin
    int k;
    int r;
    pend_m = '0;
    e_ready = 1'b0;
    pop_m = 1'b0;
    e_we = 1'b0;
    e_wa = '0;
    e_wd = '0;
    idle_inputs();

    // Reset held two cycles with a secondary offer present.
    reset = 1'b1;
    sec_valid = 1'b1;
    sec_rd = 5'd3;
    sec_data = 32'h1234;
    tick();
    settle();
    check("rst_sec_ready", sec_ready, 1'b0);
    check("rst_pending", pending, 32'd0);
    tick();
    reset = 1'b0;
    sec_valid = 1'b0;
    settle();
    check("post_rst_ready", sec_ready, 1'b1);
    tick();

    // Primary writeback, zero latency; x0 suppressed.
    pri_valid = 1'b1; pri_rd = 5'd5; pri_data = 32'hDEADBEEF;
    settle();
    check("pri_we", rf_we, 1'b1);
    check("pri_wa", rf_wa, 5'd5);
    check("pri_wd", rf_wd, 32'hDEADBEEF);
    tick();
    pri_rd = 5'd0;
    settle();
    check("pri_x0_we", rf_we, 1'b0);
    tick();
    pri_valid = 1'b0;

    // Scoreboard set by issue, cleared by the queued commit.
    iss_valid = 1'b1; iss_rd = 5'd7;
    settle(); tick();
    iss_valid = 1'b0; rs1 = 5'd7;
    settle();
    check("sb_pend7", pending[7], 1'b1);
    check("sb_stall7", stall, 1'b1);
    tick();
    sec_valid = 1'b1; sec_rd = 5'd7; sec_data = 32'h11;
    settle(); tick();
    sec_valid = 1'b0;
    settle();
    check("sb_commit_we", rf_we, 1'b1);
    check("sb_commit_wa", rf_wa, 5'd7);
    check("sb_commit_wd", rf_wd, 32'h11);
    tick();
    settle();
    check("sb_clear7", pending[7], 1'b0);
    tick();
    rs1 = 5'd0;

    // Contention: primary held while the queue fills with rd 1..4.
    pri_valid = 1'b1; pri_rd = 5'd20; sec_valid = 1'b1;
    k = 1;
    for (int c = 0; c < 6; c++) begin
      pri_data = $urandom;
      sec_rd = 5'(k);
      sec_data = 32'(k) * 32'h100;
      settle();
      check("cont_pri_wa", rf_wa, 5'd20);
      tick();
      if (acc_m) k++;
    end
    check("cont_accepts", k, 5);
    pri_valid = 1'b0; sec_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      if (i == 1) check("cont_full_ready", sec_ready, 1'b0);
      check("drain_we", rf_we, 1'b1);
      check("drain_wa", rf_wa, 5'(i));
      check("drain_wd", rf_wd, 32'(i) * 32'h100);
      tick();
    end

    // Set/clear collision on rd 9: set wins.
    iss_valid = 1'b1; iss_rd = 5'd9;
    settle(); tick();
    iss_valid = 1'b0; sec_valid = 1'b1; sec_rd = 5'd9; sec_data = 32'h99;
    settle(); tick();
    sec_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9;
    settle();
    check("coll_we", rf_we, 1'b1);
    tick();
    iss_valid = 1'b0;
    settle();
    check("coll_pend9", pending[9], 1'b1);
    tick();

`ifdef OTTER_WB_BYPASS_EN
    iss_valid = 1'b1; iss_rd = 5'd7;
    settle(); tick();
    iss_valid = 1'b0; sec_valid = 1'b1; sec_rd = 5'd7; sec_data = 32'h42;
    settle(); tick();
    sec_valid = 1'b0; rs2 = 5'd7;
    settle();
    check("byp2_hit_dir", byp2_hit, 1'b1);
    check("byp2_data_dir", byp2_data, 32'h42);
    check("byp_stall_dir", stall, 1'b0);
    tick();
    rs2 = 5'd0;
`endif

    reset = 1'b1;
    settle(); tick();
    reset = 1'b0;
    out_q.delete();

    // Randomized traffic respecting the issuer obligations.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      pri_valid = $urandom_range(0, 1);
      r = $urandom_range(0, 31);
      pri_rd = pend_m[r] ? 5'd0 : 5'(r);
      pri_data = $urandom;
      r = $urandom_range(1, 31);
      iss_valid = ($urandom_range(0, 2) == 0) && !pend_m[r];
      iss_rd = 5'(r);
      sec_data = $urandom;
      if (out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        sec_valid = 1'b1;
        sec_rd = out_q[0];
      end else if ($urandom_range(0, 7) == 0) begin
        sec_valid = 1'b1;
        sec_rd = 5'd0;
      end else begin
        sec_valid = 1'b0;
        sec_rd = 5'd0;
      end
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      settle();
      tick();
      if (reset) begin
        out_q.delete();
      end else begin
        if (acc_m && sec_rd != 0) void'(out_q.pop_front());
        if (iss_valid) out_q.push_back(iss_rd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
